// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core. Sequences fetch, decode, execute,
// memory and writeback over a shared datapath and counts retired instructions.
// Any illegal opcode or memory timeout parks the FSM in a sticky trap state.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    localparam logic [31:0] TimeoutLim = 32'(TIMEOUT);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] instret_q, instret_d;
    logic        trap_q, trap_d;
    logic [1:0]  cause_q, cause_d;

    logic [6:0] opcode;
    logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
    logic legal;
    logic sel_a, sel_b;
    logic wait_expired;
    logic unused_inst;

    // Only the opcode field steers control; the rest of inst feeds the datapath.
    assign unused_inst = ^inst[31:7];

    assign opcode   = inst[6:0];
    assign is_r     = (opcode == OpR);
    assign is_i     = (opcode == OpI);
    assign is_ld    = (opcode == OpLoad);
    assign is_st    = (opcode == OpStore);
    assign is_br    = (opcode == OpBr);
    assign is_lui   = (opcode == OpLui);
    assign is_auipc = (opcode == OpAuipc);
    assign is_jal   = (opcode == OpJal);
    assign is_jalr  = (opcode == OpJalr);
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_lui | is_auipc | is_jal | is_jalr;

    // ALU operand selects held through EXEC, MEM and WB
    assign sel_a = is_auipc;
    assign sel_b = is_i | is_ld | is_st | is_jalr | is_auipc;

    // A zero TIMEOUT disables the memory wait limit
    assign wait_expired = (TimeoutLim != 32'd0) && ((wait_q + 32'd1) == TimeoutLim);

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

    // Next-state, wait counter and combinational control decode
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;

        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                    wait_d  = 32'd0;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    wait_d  = 32'd0;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end
            end
            StExec: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                if (is_ld || is_st) begin
                    state_d = StMem;
                end else if (is_br) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                dmem_req  = 1'b1;
                dmem_we   = is_st;
                if (dmem_ready) begin
                    wait_d = 32'd0;
                    if (is_st) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_expired) begin
                    state_d = StTrap;
                    wait_d  = 32'd0;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StWb: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
                if (is_ld) begin
                    wb_sel = 2'b01;
                end else if (is_jal || is_jalr) begin
                    wb_sel = 2'b10;
                end else if (is_lui) begin
                    wb_sel = 2'b11;
                end
                if (is_jal) begin
                    pc_sel = 2'b01;
                end else if (is_jalr) begin
                    pc_sel = 2'b10;
                end
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
                wait_d  = 32'd0;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wait_q    <= 32'd0;
            instret_q <= 32'd0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions are
// checked per transaction against expectations derived from instruction class.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] inst = 32'd0;
    logic        br_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we;
    logic        dmem_req, dmem_we, retire, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [31:0] instret;
    logic [12:0] outs;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_instret = 32'd0;

    multicycle_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .br_taken   (br_taken),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // All combinational controls; imem_req is the MSB
    assign outs = {imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                   rf_we, wb_sel, dmem_req, dmem_we, retire};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Called at a negedge; returns at a negedge with FETCH running
    task automatic do_reset();
        @(negedge clk);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        br_taken   = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("rst_outs", 32'(outs), 32'h1000);
        check("rst_trap", 32'({trap_cause, trap}), 32'd0);
        check("rst_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_instret = 32'd0;
    endtask

    // One legal instruction with iw fetch waits and dw data waits.
    // Called at a negedge in FETCH; returns at the negedge after retirement.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic br);
        logic [6:0] op;
        logic       is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr, is_imm;
        int         exp_cyc, exp_rf, exp_dreq, exp_dwe, ms, c;
        logic [1:0] exp_pcsel, exp_wb;
        int         n_ireq, n_irwe, n_pcwe, n_rf, n_dreq, n_dwe, n_ret;
        logic [1:0] fin_pcsel, fin_wb;
        logic       fin_a, fin_b, done;
        string      pfx;

        op       = ins[6:0];
        is_ld    = (op == 7'b0000011);
        is_st    = (op == 7'b0100011);
        is_br    = (op == 7'b1100011);
        is_lui   = (op == 7'b0110111);
        is_auipc = (op == 7'b0010111);
        is_jal   = (op == 7'b1101111);
        is_jalr  = (op == 7'b1100111);
        is_imm   = (op == 7'b0010011) | is_ld | is_st | is_jalr | is_auipc;

        exp_cyc   = (iw + 1) + 1 + 1 + ((is_ld | is_st) ? dw + 1 : 0) + ((is_br | is_st) ? 0 : 1);
        exp_rf    = (is_br | is_st) ? 0 : 1;
        exp_dreq  = (is_ld | is_st) ? dw + 1 : 0;
        exp_dwe   = is_st ? dw + 1 : 0;
        exp_pcsel = is_br ? {1'b0, br} : is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
        exp_wb    = is_ld ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
        ms        = iw + 3;

        n_ireq = 0; n_irwe = 0; n_pcwe = 0; n_rf = 0; n_dreq = 0; n_dwe = 0; n_ret = 0;
        fin_pcsel = 2'b00; fin_wb = 2'b00; fin_a = 1'b0; fin_b = 1'b0;
        c = 0;
        done = 1'b0;
        pfx = $sformatf("%08h", ins);

        while (!done && c < 200) begin
            inst     = ins;
            br_taken = br;
            // Ready pulses outside their own wait window must be ignored
            imem_ready = (c < iw) ? 1'b0 : (c == iw) ? 1'b1 : rbit();
            if (c < ms)            dmem_ready = rbit();
            else if (c < ms + dw)  dmem_ready = 1'b0;
            else if (c == ms + dw) dmem_ready = 1'b1;
            else                   dmem_ready = rbit();
            #1;
            if (imem_req === 1'b1) n_ireq++;
            if (ir_we === 1'b1)    n_irwe++;
            if (pc_we === 1'b1)    n_pcwe++;
            if (rf_we === 1'b1)    n_rf++;
            if (dmem_req === 1'b1) n_dreq++;
            if (dmem_we === 1'b1)  n_dwe++;
            if (retire === 1'b1) begin
                n_ret++;
                fin_pcsel = pc_sel;
                fin_wb    = wb_sel;
                fin_a     = alu_a_sel;
                fin_b     = alu_b_sel;
            end
            if (retire === 1'b1 || trap === 1'b1) done = 1'b1;
            c++;
            @(negedge clk);
        end
        model_instret = model_instret + 32'd1;

        check({pfx, " cycles"},   32'(c),         32'(exp_cyc));
        check({pfx, " retire"},   32'(n_ret),     32'd1);
        check({pfx, " pc_we"},    32'(n_pcwe),    32'd1);
        check({pfx, " ir_we"},    32'(n_irwe),    32'd1);
        check({pfx, " imem_req"}, 32'(n_ireq),    32'(iw + 1));
        check({pfx, " rf_we"},    32'(n_rf),      32'(exp_rf));
        check({pfx, " dmem_req"}, 32'(n_dreq),    32'(exp_dreq));
        check({pfx, " dmem_we"},  32'(n_dwe),     32'(exp_dwe));
        check({pfx, " pc_sel"},   32'(fin_pcsel), 32'(exp_pcsel));
        check({pfx, " wb_sel"},   32'(fin_wb),    32'(exp_wb));
        check({pfx, " alu_a"},    32'(fin_a),     32'(is_auipc));
        check({pfx, " alu_b"},    32'(fin_b),     32'(is_imm));
        check({pfx, " trap"},     32'(trap),      32'd0);
        check({pfx, " instret"},  instret,        model_instret);
    endtask

    // Illegal opcode: trap after DECODE, then stays silent for 20 cycles
    task automatic illegal_test(input logic [31:0] ins);
        int bad;
        inst       = ins;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ready = rbit();
            dmem_ready = rbit();
            br_taken   = rbit();
            #1;
            if (outs !== 13'd0 || trap !== 1'b1 || trap_cause !== 2'b01 ||
                instret !== model_instret) bad++;
            @(negedge clk);
        end
        check("illegal_trap", 32'(trap), 32'd1);
        check("illegal_cause", 32'(trap_cause), 32'd1);
        check("illegal_quiet_cycles", 32'(bad), 32'd0);
        check("illegal_instret", instret, model_instret);
    endtask

    localparam logic [6:0] LegalOps [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                            7'b1100111};

    initial begin
        logic [31:0] r;
        int          n;
        int          n_ret;
        logic        seen;

        do_reset();

        // Directed instructions
        run_instr(32'h00500093, 0, 0, 1'b0);  // ADDI
        run_instr(32'h0000A103, 0, 3, 1'b0);  // LW, 3 data waits
        run_instr(32'h00000463, 0, 0, 1'b1);  // BEQ taken
        run_instr(32'h00000463, 0, 0, 1'b0);  // BEQ not taken
        run_instr(32'h000080E7, 0, 0, 1'b0);  // JALR
        run_instr(32'h0020A023, 0, 0, 1'b0);  // SW
        run_instr(32'h123450B7, 2, 0, 1'b0);  // LUI with fetch waits
        run_instr(32'h00001097, 1, 0, 1'b0);  // AUIPC
        run_instr(32'h008000EF, 0, 0, 1'b0);  // JAL
        run_instr(32'h002081B3, 3, 0, 1'b0);  // ADD

        // Random legal instructions and wait patterns
        for (int k = 0; k < 40; k++) begin
            r = $urandom();
            run_instr({r[31:7], LegalOps[$urandom_range(8, 0)]},
                      int'($urandom_range(5, 0)), int'($urandom_range(5, 0)), rbit());
        end

        // Illegal opcodes
        illegal_test(32'hFFFFFFFF);
        do_reset();
        illegal_test(32'h00000010);

        // Instruction memory timeout
        do_reset();
        imem_ready = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (trap === 1'b1) seen = 1'b1;
            else if (imem_req === 1'b1) n++;
            @(negedge clk);
        end
        check("imem_timeout_cycles", 32'(n), 32'd16);
        check("imem_timeout_trap", 32'(trap), 32'd1);
        check("imem_timeout_cause", 32'(trap_cause), 32'd2);

        // Data memory timeout on a load
        do_reset();
        inst = 32'h0000A103;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        n = 0;
        n_ret = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (trap === 1'b1) seen = 1'b1;
            else if (dmem_req === 1'b1) n++;
            if (retire === 1'b1) n_ret++;
            @(negedge clk);
            imem_ready = 1'b0;
        end
        check("dmem_timeout_cycles", 32'(n), 32'd16);
        check("dmem_timeout_cause", 32'(trap_cause), 32'd3);
        check("dmem_timeout_retire", 32'(n_ret), 32'd0);
        check("dmem_timeout_instret", instret, 32'd0);

        // Reset during MEM of a load aborts it
        do_reset();
        inst = 32'h0000A103;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_in_mem", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_outs", 32'(outs), 32'h1000);
        check("abort_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        check("abort_hold_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_instret = 32'd0;
        run_instr(32'h00500093, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
